// File: rtl/seq_detector.sv
// Parametrised serial pattern detector with elaboration-built automaton.
// Optional SEQDET_STICKY_EN adds a sticky `seen` output.
module seq_detector #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter bit             MEALY   = 1'b0,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             clr,
  output logic             z,
`ifdef SEQDET_STICKY_EN
  output logic             seen,
`endif
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int SW = (LEN > 2) ? $clog2(LEN) : 1;

  if (LEN < 2 || LEN > 16) begin : g_len_err
    $error("seq_detector: LEN must be 2..16");
  end

  // i-th bit of the pattern in arrival order
  function automatic bit pb(int i);
    logic [LEN-1:0] t;
    t = PATTERN >> (LEN - 1 - i);
    return t[0];
  endfunction

  function automatic int border();
    int best;
    bit ok;
    best = 0;
    for (int k = 1; k < LEN; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (pb(i) != pb(LEN - k + i)) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  function automatic int step_of(int s, bit b);
    int best;
    int n;
    int idx;
    bit ok;
    bit c;
    if (s == LEN - 1 && b == pb(LEN - 1))
      return OVERLAP ? border() : 0;
    best = 0;
    n = s + 1;
    for (int k = 1; k < LEN; k++) begin
      if (k <= n) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          idx = n - k + i;
          c = (idx == s) ? b : pb(idx);
          if (c != pb(i)) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  logic [SW-1:0] tbl [2*LEN];

  for (genvar s = 0; s < LEN; s++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_col
      localparam int N = step_of(s, b == 1);
      assign tbl[2*s+b] = SW'(N);
    end
  end

  logic [SW-1:0] s_q;
  logic [SW-1:0] s_nxt;
  logic          hit;
  logic          hit_q;

  always_comb begin
    s_nxt = s_q;
    hit   = en && (s_q == SW'(LEN - 1)) && (x == PATTERN[0]);
    if (en) s_nxt = tbl[{s_q, x}];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q     <= '0;
      hit_q   <= 1'b0;
      hit_cnt <= '0;
    end else begin
      s_q   <= s_nxt;
      hit_q <= hit;
      if (clr)
        hit_cnt <= CNT_W'(hit);
      else if (hit && !(&hit_cnt))
        hit_cnt <= hit_cnt + 1'b1;
    end
  end

  assign z = MEALY ? (hit && !reset) : hit_q;

`ifdef SEQDET_STICKY_EN
  always_ff @(posedge clk) begin
    if (reset || clr) seen <= 1'b0;
    else if (hit)     seen <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: four configurations share one stream and
// are checked against a history-window reference model.
module tb_seq_detector;

  localparam int LEN = 4;
  localparam logic [3:0] P = 4'b1011;

  logic clk = 1'b0;
  logic reset, en, x, clr;
  logic z0, z1, z2, z3;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;
`ifdef SEQDET_STICKY_EN
  logic s0, s1, s2, s3;
  bit   msn;
`endif

  int total = 0;
  int bad = 0;

  bit hov[$];
  bit hnv[$];
  bit qov, qnv;
  int m0, m1, m3;

  always #5 clk = ~clk;

  seq_detector d0 (
    .clk(clk), .reset(reset), .en(en), .x(x), .clr(clr),
    .z(z0),
`ifdef SEQDET_STICKY_EN
    .seen(s0),
`endif
    .hit_cnt(c0));

  seq_detector #(.OVERLAP(1'b0)) d1 (
    .clk(clk), .reset(reset), .en(en), .x(x), .clr(clr),
    .z(z1),
`ifdef SEQDET_STICKY_EN
    .seen(s1),
`endif
    .hit_cnt(c1));

  seq_detector #(.MEALY(1'b1)) d2 (
    .clk(clk), .reset(reset), .en(en), .x(x), .clr(clr),
    .z(z2),
`ifdef SEQDET_STICKY_EN
    .seen(s2),
`endif
    .hit_cnt(c2));

  seq_detector #(.CNT_W(2)) d3 (
    .clk(clk), .reset(reset), .en(en), .x(x), .clr(clr),
    .z(z3),
`ifdef SEQDET_STICKY_EN
    .seen(s3),
`endif
    .hit_cnt(c3));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // a match is the last LEN-1 kept bits plus the new bit equal to P
  function automatic bit match(bit h[$], bit b);
    int n;
    n = h.size();
    if (n < LEN - 1) return 1'b0;
    for (int i = 0; i < LEN - 1; i++)
      if (h[n - (LEN - 1) + i] != P[LEN - 1 - i]) return 1'b0;
    return b == P[0];
  endfunction

  function automatic int bump(int cur, bit h, bit c, int max);
    if (c) return h ? 1 : 0;
    if (h && cur < max) return cur + 1;
    return cur;
  endfunction

  task automatic step(bit r, bit e, bit b, bit c);
    bit ho, hn;
    reset = r;
    en    = e;
    x     = b;
    clr   = c;
    #1;
    ho = e && match(hov, b);
    hn = e && match(hnv, b);
    chk("mealy_z", 32'(z2), 32'(ho && !r));
    @(posedge clk);
    if (r) begin
      hov.delete();
      hnv.delete();
      qov = 0;
      qnv = 0;
      m0 = 0;
      m1 = 0;
      m3 = 0;
    end else begin
      qov = ho;
      qnv = hn;
      m0 = bump(m0, ho, c, 255);
      m1 = bump(m1, hn, c, 255);
      m3 = bump(m3, ho, c, 3);
      if (e) begin
        hov.push_back(b);
        if (hov.size() > LEN) void'(hov.pop_front());
        if (hn) hnv.delete();
        else begin
          hnv.push_back(b);
          if (hnv.size() > LEN) void'(hnv.pop_front());
        end
      end
    end
`ifdef SEQDET_STICKY_EN
    if (r || c) msn = 0;
    else if (ho) msn = 1;
`endif
    #1;
    chk("ovl_z", 32'(z0), 32'(qov));
    chk("ovl_cnt", 32'(c0), 32'(m0));
    chk("nov_z", 32'(z1), 32'(qnv));
    chk("nov_cnt", 32'(c1), 32'(m1));
    chk("mly_cnt", 32'(c2), 32'(m0));
    chk("sat_z", 32'(z3), 32'(qov));
    chk("sat_cnt", 32'(c3), 32'(m3));
`ifdef SEQDET_STICKY_EN
    chk("seen", 32'(s0), 32'(msn));
`endif
  endtask

  task automatic feed(logic [31:0] bits, int n);
    for (int i = n - 1; i >= 0; i--) step(0, 1, bits[i], 0);
  endtask

  initial begin
    reset = 1;
    en = 0;
    x = 0;
    clr = 0;
    #1;
    step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    chk("rst_z", 32'(z0), 0);
    chk("rst_cnt", 32'(c0), 0);

    feed(32'b1011011, 7);
    chk("p1_cnt", 32'(c0), 2);
    chk("p2_cnt", 32'(c1), 1);
    chk("p3_cnt", 32'(c2), 2);

    step(1, 0, 0, 0);
    feed(32'b10, 2);
    for (int i = 0; i < 3; i++) step(0, 0, i[0], 0);
    feed(32'b11, 2);
    chk("p4_cnt", 32'(c0), 1);

    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) feed(32'b1011, 4);
    chk("sat3", 32'(c3), 3);
    chk("nosat", 32'(c0), 5);
    feed(32'b101, 3);
    step(0, 1, 1, 1);
    chk("clr_hit", 32'(c3), 1);
    chk("clr_hit8", 32'(c0), 1);

    step(1, 0, 0, 0);
    feed(32'b101, 3);
    step(1, 1, 1, 0);
    step(0, 1, 1, 0);
    chk("rst_mid_cnt", 32'(c0), 0);
    chk("rst_mid_z", 32'(z0), 0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 31) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
Name: seq_detector

Overview:
Parametrised serial pattern detector, the successor to the fixed two-JK-flip-flop example machine.
- Watches a 1-bit input stream `x`, one bit per enabled clock.
- Flags each occurrence of a compile-time pattern of length LEN.
- Selectable overlapping/non-overlapping matching and Mealy/Moore output timing.
- Saturating hit counter.
- Used as a reusable lab/test block wherever a serial-sequence recogniser is needed.

Parameters:
- LEN, 4: pattern length in bits. Legal range 2..16; elaboration error outside it.
- PATTERN, 4'b1011: pattern to match. PATTERN[LEN-1] is the first bit received.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = the bits of a match are not reused.
- MEALY, 0: 1 = combinational `z` in the cycle of the final bit; 0 = registered `z` one cycle later.
- CNT_W, 8: width of the hit counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- en  input  1  bit-valid; `x` is sampled only when en=1
- x  input  1  serial data bit
- clr  input  1  synchronous clear of hit_cnt (and of `seen`, if compiled in)
- z  output  1  match indication
- hit_cnt  output  CNT_W  number of matches, saturating

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `reset`, sampled on the rising edge of `clk`.
- Reset values: S=0, hit_q=0, hit_cnt=0; z=0 in both modes. Mealy z is 0 while reset=1.
- State register S (width clog2(LEN)): length of the longest pattern prefix that equals a suffix of the bits received so far. Range 0..LEN-1.
- Next-state table: built at elaboration (KMP-style automaton) from PATTERN, LEN and OVERLAP. No runtime pattern logic.
- hit (combinational) = en & (S==LEN-1) & (x==PATTERN[0]).
- Next state when en=1:
  - hit & OVERLAP=1: S' = F(LEN), the longest proper prefix of PATTERN that is also its suffix.
  - hit & OVERLAP=0: S' = 0.
  - otherwise: S' = longest k<LEN such that the first k pattern bits equal the last k bits of (matched prefix of length S followed by x).
- en=0: S holds; hit=0.
- Output z:
  - MEALY=1: z = hit, combinational from x, en and S.
  - MEALY=0: hit_q <= hit every clock; z = hit_q. z is high exactly one cycle after the final bit's edge. Because hit=0 when en=0, en=0 in the final-bit cycle yields z=0 next cycle.
- hit_cnt, priority reset > clr > hit:
  - reset: 0.
  - clr=1: loads 1 if hit else 0, so a same-cycle hit is not lost.
  - clr=0 and hit=1: increments, saturating at 2^CNT_W-1. Never wraps.
- Counting uses `hit` (final-bit cycle) in both modes, so hit_cnt updates on the same edge regardless of MEALY.
- Reset mid-pattern: partial match discarded. The first bit after reset is treated as stream start.

Optional Feature:
- Macro: SEQDET_STICKY_EN.
- Defined: adds output `seen` (1 bit, registered). Set on the first edge where hit=1; stays high until reset or clr. reset/clr win over a same-cycle hit, so `seen` is 0 after that edge.
- Not defined: no `seen` port and no sticky register; behaviour otherwise identical.

Test Plan:
1. LEN=4, PATTERN=1011, OVERLAP=1, MEALY=0: apply reset, then en=1, x=1,0,1,1,0,1,1 on edges 1..7 -> z=1 in the cycles after edges 4 and 7 only; hit_cnt=2.
2. Same stream, OVERLAP=0 -> z=1 only after edge 4; S=1 after edge 7; hit_cnt=1.
3. MEALY=1, OVERLAP=1, same stream -> z=1 combinationally during the edge-4 and edge-7 bit cycles, 0 otherwise; hit_cnt=2.
4. OVERLAP=1, MEALY=0, stream 1,0,1 with en=0 inserted for 3 cycles between bits 2 and 3, then 1 -> S holds at 2 during en=0; match still detected, z=1 after the final bit; hit_cnt=1.
5. CNT_W=2, OVERLAP=1: feed 1011 repeated 5 times (each repeat a full non-overlapping copy) -> hit_cnt saturates at 3. Then clr=1 asserted on the same edge as a hit -> hit_cnt=1.
6. Reset asserted after 1,0,1, then x=1 -> no match; S=1 after that bit; hit_cnt=0, z=0. With SEQDET_STICKY_EN defined, `seen` stays 0.
